spi_access: RTL and testbench

- Zorro III slave-register front end and SPI byte engine for the on-card SPI port (SPI_CLK/SPI_MOSI/SPI_MISO/SPI_CS_n).
- Decodes a window in the card's unused 0x900000+ board-space region.
- Sits beside rom_access/sid_access/intreg_access: consumes the latched address, READ, synchronised FCS_n and slave_cycle from the top level, and produces spi_dtack into the Z3 cycle state machine plus read data for the D[31:24] mux.
- SPI mode 0, MSB first, one byte per transfer; software drives chip select through a control bit.

---
 rtl/spi_access.sv | 180 ++++++++++++++++++
 tb/tb_spi_access.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_access.sv
// Zorro III slave register window and SPI mode-0 byte engine (MSB first, software chip select).
// The bus side stalls DATA accesses and CTRL writes while a byte is on the wire.
module spi_access #(
  parameter int unsigned CLK_DIV = 2,
  parameter logic [4:0]  WIN     = 5'b10010
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [27:0] ADDR,
  input  logic        READ,
  input  logic        FCS_n,
  input  logic        slave_cycle,
  input  logic        configured,
  input  logic [7:0]  DIN,
  output logic [7:0]  DOUT,
  output logic        spi_dtack,
  output logic        busy,
  input  logic        SPI_MISO,
  output logic        SPI_MOSI,
  output logic        SPI_CLK,
  output logic        SPI_CS_n
);

  localparam int unsigned    DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  typedef enum logic [1:0] {B_IDLE, B_WAIT, B_ACK} bus_state_e;
  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} spi_state_e;

  bus_state_e      bus_q, bus_d;
  spi_state_e      spi_q, spi_d;
  logic            cs_n_q, cs_n_d;
  logic [7:0]      tx_q, tx_d;
  logic            start_q, start_d;
  logic [7:0]      dout_q, dout_d;
  logic [DivW-1:0] div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      txsh_q, txsh_d;
  logic [7:0]      rxsh_q, rxsh_d;
  logic [7:0]      rx_q, rx_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            busy_q, busy_d;
  logic            spi_done;
  logic            sel, is_ctrl, accept;

  // Window aliases: only ADDR[23:19] and ADDR[2] are decoded.
  logic unused_addr;
  assign unused_addr = ^{ADDR[27:24], ADDR[18:3], ADDR[1:0]};

  assign sel     = configured && slave_cycle && !FCS_n && (ADDR[23:19] == WIN);
  assign is_ctrl = ADDR[2];
  // spi_done lets a stalled access complete on the very edge busy falls.
  assign accept  = (is_ctrl && READ) || !(busy_q || start_q) || spi_done;

  always_comb begin
    spi_d    = spi_q;
    div_d    = div_q;
    bit_d    = bit_q;
    txsh_d   = txsh_q;
    rxsh_d   = rxsh_q;
    rx_d     = rx_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    busy_d   = busy_q;
    spi_done = 1'b0;
    unique case (spi_q)
      S_IDLE: begin
        if (start_q) begin
          txsh_d = tx_q;
          mosi_d = tx_q[7];
          bit_d  = '0;
          div_d  = '0;
          busy_d = 1'b1;
          spi_d  = S_LOW;
        end
      end
      S_LOW: begin
        if (div_q == DivLast) begin
          div_d  = '0;
          sclk_d = 1'b1;
          rxsh_d = {rxsh_q[6:0], SPI_MISO};
          spi_d  = S_HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (div_q == DivLast) begin
          div_d  = '0;
          sclk_d = 1'b0;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            spi_done = 1'b1;
            busy_d   = 1'b0;
            rx_d     = rxsh_q;
            spi_d    = S_IDLE;
          end else begin
            txsh_d = {txsh_q[6:0], 1'b0};
            mosi_d = txsh_q[6];
            spi_d  = S_LOW;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: spi_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_d   = bus_q;
    cs_n_d  = cs_n_q;
    tx_d    = tx_q;
    start_d = 1'b0;
    dout_d  = dout_q;
    unique case (bus_q)
      B_IDLE: if (sel) bus_d = B_WAIT;
      B_WAIT: begin
        if (FCS_n) begin
          bus_d = B_IDLE;
        end else if (accept) begin
          bus_d = B_ACK;
          if (READ) begin
            dout_d = is_ctrl ? {6'b0, busy_q, !cs_n_q} : rx_d;
          end else if (is_ctrl) begin
            cs_n_d = !DIN[0];
          end else begin
            tx_d    = DIN;
            start_d = 1'b1;
          end
        end
      end
      B_ACK: if (FCS_n) bus_d = B_IDLE;
      default: bus_d = B_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bus_q   <= B_IDLE;
      spi_q   <= S_IDLE;
      cs_n_q  <= 1'b1;
      tx_q    <= 8'h00;
      start_q <= 1'b0;
      dout_q  <= 8'h00;
      div_q   <= '0;
      bit_q   <= 3'd0;
      txsh_q  <= 8'h00;
      rxsh_q  <= 8'h00;
      rx_q    <= 8'h00;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      bus_q   <= bus_d;
      spi_q   <= spi_d;
      cs_n_q  <= cs_n_d;
      tx_q    <= tx_d;
      start_q <= start_d;
      dout_q  <= dout_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      txsh_q  <= txsh_d;
      rxsh_q  <= rxsh_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
    end
  end

  assign DOUT      = dout_q;
  assign spi_dtack = (bus_q == B_ACK);
  assign busy      = busy_q;
  assign SPI_MOSI  = mosi_q;
  assign SPI_CLK   = sclk_q;
  assign SPI_CS_n  = cs_n_q;

endmodule

// File: tb/tb_spi_access.sv
// Directed bench for spi_access: register access, byte transfer timing, stalls, aborts, reset.
module tb_spi_access;

  localparam int ClkPeriod = 10;

  logic        CLK, RESET, READ, FCS_n, slave_cycle, configured;
  logic [27:0] ADDR;
  logic [7:0]  DIN, DOUT;
  logic        spi_dtack, busy, SPI_MISO, SPI_MOSI, SPI_CLK, SPI_CS_n;

  spi_access #(.CLK_DIV(2), .WIN(5'b10010)) dut (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .READ(READ), .FCS_n(FCS_n),
    .slave_cycle(slave_cycle), .configured(configured), .DIN(DIN), .DOUT(DOUT),
    .spi_dtack(spi_dtack), .busy(busy), .SPI_MISO(SPI_MISO), .SPI_MOSI(SPI_MOSI),
    .SPI_CLK(SPI_CLK), .SPI_CS_n(SPI_CS_n)
  );

  initial CLK = 1'b0;
  always #(ClkPeriod / 2) CLK = ~CLK;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  // Free-running monitors; the stimulus block takes differences against snapshots.
  int          busy_total = 0;
  int          rise_total = 0;
  logic [15:0] mosi_sh    = 16'h0;
  time         last_rise  = 0;
  time         rise_period = 0;
  logic [15:0] miso_pat   = 16'h0;
  int          miso_base  = 0;
  int          miso_idx;

  always @(posedge CLK) if (busy) busy_total++;

  always @(posedge SPI_CLK) begin
    rise_total++;
    mosi_sh     = {mosi_sh[14:0], SPI_MOSI};
    rise_period = $time - last_rise;
    last_rise   = $time;
  end

  // Device model: presents miso_pat MSB first, advancing after each SPI_CLK rise.
  always_comb begin
    miso_idx = rise_total - miso_base;
    SPI_MISO = 1'b0;
    if (miso_idx >= 0 && miso_idx < 16) SPI_MISO = miso_pat[4'(15 - miso_idx)];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic z3_access(input logic [27:0] a, input logic rd, input logic [7:0] d,
                           input int limit, output logic ack, output int n,
                           output logic busy_prev);
    ADDR = a; READ = rd; DIN = d; slave_cycle = 1'b1; FCS_n = 1'b0;
    ack = 1'b0; n = 0; busy_prev = busy;
    while (!ack && n < limit) begin
      busy_prev = busy;
      tick();
      n++;
      ack = spi_dtack;
    end
  endtask

  task automatic z3_end();
    FCS_n = 1'b1;
    tick();
    slave_cycle = 1'b0;
    READ = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output logic ok);
    int n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    ok = !busy;
  endtask

  logic ack, bp, ok;
  int   n, base_busy, base_rise;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; FCS_n = 1'b1; slave_cycle = 1'b0; configured = 1'b1;
    ADDR = 28'h0; READ = 1'b0; DIN = 8'h00;
    tick(); tick();
    check("rst_cs_n", 32'(SPI_CS_n), 1);
    check("rst_sclk", 32'(SPI_CLK), 0);
    check("rst_dtack", 32'(spi_dtack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_mosi", 32'(SPI_MOSI), 0);
    RESET = 1'b0;
    tick();
    z3_access(28'h0900004, 1'b1, 8'h00, 10, ack, n, bp);
    check("rst_ctrl_ack", 32'(ack), 1);
    check("rst_ctrl_read", 32'(DOUT), 32'h00);
    z3_end();

    // CTRL write enables chip select
    z3_access(28'h0900004, 1'b0, 8'h01, 10, ack, n, bp);
    check("ctrl_wr_ack", 32'(ack), 1);
    check("ctrl_wr_latency", n, 2);
    check("ctrl_wr_cs_n", 32'(SPI_CS_n), 0);
    tick(); tick(); tick();
    check("dtack_hold", 32'(spi_dtack), 1);
    z3_end();
    check("dtack_drop", 32'(spi_dtack), 0);

    // Single byte A5 out, 3C in
    miso_pat = {8'h3C, 8'h00}; miso_base = rise_total; base_busy = busy_total;
    z3_access(28'h0900000, 1'b0, 8'hA5, 10, ack, n, bp);
    check("a5_ack", 32'(ack), 1);
    z3_end();
    wait_idle(100, ok);
    check("a5_done", 32'(ok), 1);
    check("a5_busy_cycles", busy_total - base_busy, 32);
    check("a5_rises", rise_total - miso_base, 8);
    check("a5_mosi", 32'(mosi_sh[7:0]), 32'hA5);
    check("a5_sclk_period", 32'(rise_period), 4 * ClkPeriod);
    check("a5_sclk_idle", 32'(SPI_CLK), 0);
    check("a5_mosi_hold", 32'(SPI_MOSI), 1);
    z3_access(28'h0900000, 1'b1, 8'h00, 10, ack, n, bp);
    check("a5_rx_read", 32'(DOUT), 32'h3C);
    z3_end();

    // Back-to-back: FF stalls behind 81
    miso_pat = {8'h96, 8'h5A}; miso_base = rise_total; base_busy = busy_total;
    z3_access(28'h0900000, 1'b0, 8'h81, 10, ack, n, bp);
    z3_end();
    z3_access(28'h0900000, 1'b0, 8'hFF, 100, ack, n, bp);
    check("b2b_ack", 32'(ack), 1);
    check("b2b_busy_before", 32'(bp), 1);
    check("b2b_busy_fall_edge", 32'(busy), 0);
    check("b2b_first_len", busy_total - base_busy, 32);
    z3_end();
    check("b2b_gap_busy", 32'(busy), 1);
    check("b2b_gap_sclk", 32'(SPI_CLK), 0);
    z3_access(28'h0900004, 1'b1, 8'h00, 10, ack, n, bp);
    check("b2b_ctrl_ack", 32'(ack), 1);
    check("b2b_ctrl_read", 32'(DOUT), 32'h03);
    z3_end();
    z3_access(28'h0900000, 1'b1, 8'h00, 100, ack, n, bp);
    check("b2b_stalled_read_ack", 32'(ack), 1);
    check("b2b_stalled_read", 32'(DOUT), 32'h5A);
    check("b2b_read_busy", 32'(busy), 0);
    z3_end();
    check("b2b_mosi", 32'(mosi_sh), 32'h81FF);
    check("b2b_rises", rise_total - miso_base, 16);

    // Stalled write abandoned by FCS_n
    miso_pat = 16'h0; miso_base = rise_total;
    z3_access(28'h0900000, 1'b0, 8'h3C, 10, ack, n, bp);
    z3_end();
    z3_access(28'h0900000, 1'b0, 8'h77, 5, ack, n, bp);
    check("abort_no_dtack", 32'(ack), 0);
    z3_end();
    check("abort_dtack_low", 32'(spi_dtack), 0);
    wait_idle(100, ok);
    for (int i = 0; i < 10; i++) tick();
    check("abort_no_restart", 32'(busy), 0);
    check("abort_rises", rise_total - miso_base, 8);

    // Decode misses
    base_rise = rise_total;
    z3_access(28'h0980000, 1'b0, 8'h55, 10, ack, n, bp);
    check("miss_window", 32'(ack), 0);
    z3_end();
    configured = 1'b0;
    z3_access(28'h0900000, 1'b0, 8'h55, 10, ack, n, bp);
    check("miss_unconfigured", 32'(ack), 0);
    z3_end();
    configured = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("miss_busy", 32'(busy), 0);
    check("miss_rises", rise_total - base_rise, 0);
    check("miss_cs_kept", 32'(SPI_CS_n), 0);

    // Reset after three bits
    miso_pat = 16'hFFFF; miso_base = rise_total;
    z3_access(28'h0900000, 1'b0, 8'hC3, 10, ack, n, bp);
    z3_end();
    n = 0;
    while ((rise_total - miso_base) < 3 && n < 100) begin
      tick();
      n++;
    end
    check("mid_rises", rise_total - miso_base, 3);
    RESET = 1'b1;
    tick();
    check("mid_rst_cs_n", 32'(SPI_CS_n), 1);
    check("mid_rst_sclk", 32'(SPI_CLK), 0);
    check("mid_rst_busy", 32'(busy), 0);
    RESET = 1'b0;
    tick();
    z3_access(28'h0900000, 1'b1, 8'h00, 10, ack, n, bp);
    check("mid_rx_discarded", 32'(DOUT), 32'h00);
    z3_end();
    z3_access(28'h0900004, 1'b1, 8'h00, 10, ack, n, bp);
    check("mid_ctrl_read", 32'(DOUT), 32'h00);
    z3_end();

    // Normal transfer after reset
    z3_access(28'h0900004, 1'b0, 8'h01, 10, ack, n, bp);
    z3_end();
    miso_pat = {8'hE7, 8'h00}; miso_base = rise_total; base_busy = busy_total;
    z3_access(28'h0900000, 1'b0, 8'h5A, 10, ack, n, bp);
    z3_end();
    wait_idle(100, ok);
    check("post_done", 32'(ok), 1);
    check("post_busy_cycles", busy_total - base_busy, 32);
    check("post_mosi", 32'(mosi_sh[7:0]), 32'h5A);
    z3_access(28'h0900000, 1'b1, 8'h00, 10, ack, n, bp);
    check("post_rx_read", 32'(DOUT), 32'hE7);
    z3_end();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
